// File: rtl/hilo_sequencer.sv
// HI/LO register pair fed by an external iterative multiplier: sequences
// load/run of the multiplier, captures the product, and aborts on timeout.
module hilo_sequencer #(
   parameter int TIMEOUT = 40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        we_hi,
   input  logic        we_lo,
   input  logic [31:0] wdata,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   output logic        mul_ena,
   output logic        mul_rst,
   input  logic [63:0] mul_p,
   input  logic        mul_dne,
   output logic [1:0]  dbg_state
);

   // Handshake: start is taken on any edge where busy is low; busy stays high
   // until the product is captured (done pulses next cycle) or the run times
   // out. mul_rst is a one-cycle load; mul_dne is only trusted in RUN.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   localparam int CW = $clog2(TIMEOUT + 1);

   state_t        state, state_nxt;
   logic [CW-1:0] run_cnt;
   logic          accept, capture, expire;

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      capture   = 1'b0;
      expire    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = LOAD;
            end
         end
         LOAD: state_nxt = RUN;
         RUN: begin
            if (mul_dne) begin
               capture   = 1'b1;
               state_nxt = IDLE;
            end else if (run_cnt == CW'(TIMEOUT - 1)) begin
               expire    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         run_cnt <= '0;
         hi      <= '0;
         lo      <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
         mul_a   <= '0;
         mul_b   <= '0;
      end else begin
         state <= state_nxt;
         done  <= capture;
         if (expire)
            err <= 1'b1;
         if (state == LOAD)
            run_cnt <= '0;
         else if (state == RUN)
            run_cnt <= run_cnt + CW'(1);
         if (accept) begin
            mul_a <= a;
            mul_b <= b;
         end
         // A direct write loses to a same-cycle start.
         if (capture) begin
            hi <= mul_p[63:32];
            lo <= mul_p[31:0];
         end else if (state == IDLE && !start) begin
            if (we_hi)
               hi <= wdata;
            if (we_lo)
               lo <= wdata;
         end
      end
   end

   assign busy      = (state != IDLE);
   assign mul_rst   = (state == LOAD);
   assign mul_ena   = (state == LOAD) || (state == RUN);
   assign dbg_state = state;

endmodule

// File: tb/tb_hilo_sequencer.sv
// Self-checking bench for hilo_sequencer: directed vector table, hand-written
// corner sequences, and randomized operations against a transaction-level model.
module tb_hilo_sequencer;

   localparam int TIMEOUT = 40;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [31:0] a = '0, b = '0;
   logic        we_hi = 1'b0, we_lo = 1'b0;
   logic [31:0] wdata = '0;
   logic [31:0] hi, lo, mul_a, mul_b;
   logic        busy, done, err, mul_ena, mul_rst;
   logic [63:0] mul_p;
   logic        mul_dne = 1'b0;
   logic [1:0]  dbg_state;

   int checks = 0;
   int failures = 0;

   hilo_sequencer #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .we_hi(we_hi), .we_lo(we_lo), .wdata(wdata),
      .hi(hi), .lo(lo), .busy(busy), .done(done), .err(err),
      .mul_a(mul_a), .mul_b(mul_b), .mul_ena(mul_ena), .mul_rst(mul_rst),
      .mul_p(mul_p), .mul_dne(mul_dne), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // Behavioural iterative multiplier: load on mul_rst, dne after mul_iters enabled cycles.
   int          mul_iters = 1;
   bit          mul_hang = 1'b0;
   int          m_cnt = 0;
   logic [63:0] m_prod = '0;
   always @(posedge clk) begin
      if (mul_rst) begin
         m_cnt   <= mul_iters;
         mul_dne <= 1'b0;
         m_prod  <= longint'($signed(mul_a)) * longint'($signed(mul_b));
      end else if (mul_ena && !mul_hang && m_cnt > 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1)
            mul_dne <= 1'b1;
      end
   end
   assign mul_p = m_prod;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      int          iters;
      bit          hang;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      int          exp_busy;
      int          exp_done;
      bit          exp_err;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input vec_t v, input bit noise, input bit we_start);
      int busy_cnt, done_cnt, rst_cnt, ena_bad, stable_bad;
      mul_iters = v.iters;
      mul_hang  = v.hang;
      a = v.a;
      b = v.b;
      start = 1'b1;
      if (we_start) begin
         we_lo = 1'b1;
         wdata = 32'h1111_1111;
      end
      tick();
      start = 1'b0;
      we_lo = 1'b0;
      a = $urandom;
      b = $urandom;
      busy_cnt = 0; done_cnt = 0; rst_cnt = 0; ena_bad = 0; stable_bad = 0;
      while (busy === 1'b1 && busy_cnt < 200) begin
         busy_cnt++;
         if (done) done_cnt++;
         if (mul_rst) rst_cnt++;
         if (!mul_ena) ena_bad++;
         if (mul_a !== v.a || mul_b !== v.b) stable_bad++;
         if (noise) begin
            start = 1'($urandom_range(0, 1));
            we_hi = 1'($urandom_range(0, 1));
            we_lo = 1'($urandom_range(0, 1));
            wdata = $urandom;
         end
         tick();
      end
      start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
      check({v.name, " busy_cycles"}, busy_cnt, v.exp_busy);
      check({v.name, " done_first_idle"}, done, v.exp_done);
      if (done) done_cnt++;
      check({v.name, " mul_rst_cycles"}, rst_cnt, 1);
      check({v.name, " mul_ena_in_busy"}, ena_bad, 0);
      check({v.name, " operands_stable"}, stable_bad, 0);
      tick();
      if (done) done_cnt++;
      check({v.name, " done_pulses"}, done_cnt, v.exp_done);
      check({v.name, " mul_ena_idle"}, mul_ena, 1'b0);
      check({v.name, " hi"}, hi, v.exp_hi);
      check({v.name, " lo"}, lo, v.exp_lo);
      check({v.name, " err"}, err, v.exp_err);
   endtask

   task automatic idle_write(input bit wh, input bit wl, input logic [31:0] d);
      we_hi = wh;
      we_lo = wl;
      wdata = d;
      tick();
      we_hi = 1'b0;
      we_lo = 1'b0;
   endtask

   vec_t        tbl[5];
   vec_t        v;
   logic [31:0] m_hi, m_lo;
   bit          m_err;
   logic [63:0] prod;

   initial begin
      tbl[0] = '{"mul_3x5",       32'd3,         32'd5,         3, 1'b0, 32'h0000_0000, 32'h0000_000F, 5, 1, 1'b0};
      tbl[1] = '{"mul_m2x7",      32'hFFFF_FFFE, 32'd7,         4, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF2, 6, 1, 1'b0};
      tbl[2] = '{"mul_0xk",       32'h0,         32'h1234_5678, 1, 1'b0, 32'h0000_0000, 32'h0000_0000, 3, 1, 1'b0};
      tbl[3] = '{"mul_min_sq",    32'h8000_0000, 32'h8000_0000, 2, 1'b0, 32'h4000_0000, 32'h0000_0000, 4, 1, 1'b0};
      tbl[4] = '{"mul_max_sq",    32'h7FFF_FFFF, 32'h7FFF_FFFF, 5, 1'b0, 32'h3FFF_FFFF, 32'h0000_0001, 7, 1, 1'b0};

      #3;
      check("reset_hi", hi, 0);
      check("reset_lo", lo, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_err", err, 0);
      check("reset_mul_ena", mul_ena, 0);
      check("reset_mul_rst", mul_rst, 0);
      check("reset_mul_a", mul_a, 0);
      @(negedge clk);
      rst = 1'b1;

      // Start is offered immediately after release.
      for (int i = 0; i < 5; i++)
         run_op(tbl[i], 1'b0, 1'b0);

      idle_write(1'b1, 1'b0, 32'hDEAD_BEEF);
      check("we_hi_hi", hi, 32'hDEAD_BEEF);
      check("we_hi_lo_kept", lo, 32'h0000_0001);
      idle_write(1'b1, 1'b1, 32'h0BAD_F00D);
      check("we_both_hi", hi, 32'h0BAD_F00D);
      check("we_both_lo", lo, 32'h0BAD_F00D);

      v = '{"timeout_noise", 32'd9, 32'd9, 1, 1'b1, 32'h0BAD_F00D, 32'h0BAD_F00D, TIMEOUT + 1, 0, 1'b1};
      run_op(v, 1'b1, 1'b1);

      v = '{"start_with_we_lo", 32'd6, 32'd7, 2, 1'b0, 32'h0, 32'd42, 4, 1, 1'b1};
      run_op(v, 1'b0, 1'b1);

      m_hi = hi; m_lo = lo; m_err = 1'b1;
      for (int n = 0; n < 30; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            v.a = $urandom;
            we_hi = 1'($urandom_range(0, 1));
            we_lo = 1'($urandom_range(0, 1));
            if (we_hi) m_hi = v.a;
            if (we_lo) m_lo = v.a;
            idle_write(we_hi, we_lo, v.a);
            check("rand_write_hi", hi, m_hi);
            check("rand_write_lo", lo, m_lo);
         end else begin
            v.name  = $sformatf("rand_op%0d", n);
            v.a     = $urandom;
            v.b     = $urandom;
            v.iters = $urandom_range(1, 8);
            v.hang  = ($urandom_range(0, 7) == 0);
            if (v.hang) begin
               m_err = 1'b1;
               v.exp_busy = TIMEOUT + 1;
               v.exp_done = 0;
            end else begin
               prod = longint'(signed'(v.a)) * longint'(signed'(v.b));
               m_hi = prod[63:32];
               m_lo = prod[31:0];
               v.exp_busy = v.iters + 2;
               v.exp_done = 1;
            end
            v.exp_hi = m_hi;
            v.exp_lo = m_lo;
            v.exp_err = m_err;
            run_op(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end
      end

      // Reset two cycles into an operation.
      mul_iters = 6;
      mul_hang = 1'b0;
      a = 32'd100; b = 32'd200; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_hi", hi, 0);
      check("midrst_lo", lo, 0);
      check("midrst_err", err, 0);
      check("midrst_mul_a", mul_a, 0);
      check("midrst_mul_b", mul_b, 0);
      check("midrst_mul_ena", mul_ena, 0);
      check("midrst_mul_rst", mul_rst, 0);
      v.iters = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done || busy) v.iters++;
      end
      check("midrst_quiet", v.iters, 0);
      @(negedge clk);
      rst = 1'b1;
      v = '{"post_reset", 32'd9, 32'hFFFF_FFFD, 3, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFE5, 5, 1, 1'b0};
      run_op(v, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hilo_sequencer.md
HILO_SEQUENCER -- requirements
Module: hilo_sequencer

Interface
REQ-001 SHALL have parameter: TIMEOUT, 40, maximum RUN-state cycles before the operation is aborted.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request a signed 32x32 multiply of a and b.
REQ-005 SHALL have ports: a, b  input  32 each  signed operands, sampled only on an accepted start.
REQ-006 SHALL have ports: we_hi, we_lo  input  1 each  direct HI/LO register write enables.
REQ-007 SHALL have port: wdata  input  32  data for we_hi/we_lo.
REQ-008 SHALL have ports: hi, lo  output  32 each  HI/LO registers.
REQ-009 SHALL have port: busy  output  1  operation in flight; HI/LO readers stall while high.
REQ-010 SHALL have port: done  output  1  one-cycle pulse on result capture.
REQ-011 SHALL have port: err  output  1  sticky timeout flag.
REQ-012 SHALL have ports: mul_a, mul_b  output  32 each  operands driven to the multiplier.
REQ-013 SHALL have ports: mul_ena, mul_rst  output  1 each  multiplier enable and synchronous load/clear.
REQ-014 SHALL have port: mul_p  input  64  multiplier product.
REQ-015 SHALL have port: mul_dne  input  1  multiplier done, level, stays high until the next load.

Function
REQ-016 SHALL implement a state register with states IDLE, LOAD and RUN.
REQ-017 In IDLE with start=1, the block SHALL latch a->mul_a and b->mul_b, set busy=1 and go to LOAD.
REQ-018 mul_rst SHALL be 1 only in LOAD; mul_ena SHALL be 1 in LOAD and RUN and 0 in IDLE; both SHALL be Moore decodes of the state register.
REQ-019 LOAD SHALL last exactly one cycle, then go to RUN; mul_dne SHALL be ignored in LOAD, because it is stale from the previous operation.
REQ-020 In RUN with mul_dne=1, the block SHALL on that edge load hi<=mul_p[63:32] and lo<=mul_p[31:0], pulse done=1 for one cycle, set busy=0 and go to IDLE.
REQ-021 The block SHALL count RUN cycles with a counter wide enough for TIMEOUT.
REQ-022 If TIMEOUT RUN cycles elapse without mul_dne, the block SHALL set err=1 (sticky until reset), go to IDLE and set busy=0, leaving hi/lo unchanged and not pulsing done.
REQ-023 mul_a and mul_b SHALL hold stable from the accepting edge until the next accepted start.
REQ-024 start while busy=1 SHALL be ignored, with no queuing.
REQ-025 we_hi and we_lo in IDLE SHALL write wdata to hi and/or lo respectively on the next edge; both may be asserted together.
REQ-026 we_hi and we_lo while busy=1 SHALL be ignored.
REQ-027 start together with we_hi or we_lo in IDLE: start SHALL win and the write SHALL be dropped.
REQ-028 Total latency SHALL be busy high for (multiplier iterations + 2) cycles, with done asserted in the cycle after busy falls.

Reset
REQ-029 On rst=0, asynchronously: state=IDLE, hi=0, lo=0, busy=0, done=0, err=0, mul_a=0, mul_b=0, mul_ena=0, mul_rst=0.
REQ-030 Reset mid-operation SHALL abandon the operation with no hi/lo update; the multiplier's internal state is irrelevant because the next LOAD reinitialises it.
REQ-031 After rst rises, start SHALL be accepted on the first clock edge.

Verification
REQ-032 a=3, b=5 with the real multiplier -> busy high 5 cycles, hi=0x00000000, lo=0x0000000F, one done pulse.
REQ-033 a=0xFFFFFFFE (-2), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFF2.
REQ-034 a=0, b=0x12345678 -> busy high 3 cycles, hi=0, lo=0; then a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000; mul_dne left high from the first operation is not captured during LOAD.
REQ-035 Behavioural multiplier model holding mul_dne=0 -> err=1 after 40 RUN cycles, busy=0, hi/lo keep their prior values, no done pulse.
REQ-036 IDLE: we_hi=1, wdata=0xDEADBEEF -> hi=0xDEADBEEF; we_lo during busy -> lo unchanged; start with we_lo in the same cycle -> multiply runs and the write is dropped.
REQ-037 rst=0 asserted 2 cycles into an operation -> all outputs at reset values immediately, no done pulse; a fresh start after release completes correctly.
